// File: rtl/verici_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : verici_pkg
//  Brief    : Shared types and Gray-code group lookups for the verici
//             encoder/decoder pair.
//  Revision : 1.0 - initial release
// ============================================================================
package verici_pkg;

    localparam int GROUP_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ENCODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [GROUP_W-1:0] enc_lut(input logic [GROUP_W-1:0] b);
        logic [GROUP_W-1:0] c;
        case (b)
            3'b000:  c = 3'b000;
            3'b001:  c = 3'b001;
            3'b010:  c = 3'b011;
            3'b011:  c = 3'b010;
            3'b100:  c = 3'b110;
            3'b101:  c = 3'b111;
            3'b110:  c = 3'b101;
            default: c = 3'b100;
        endcase
        return c;
    endfunction

    function automatic logic [GROUP_W-1:0] dec_lut(input logic [GROUP_W-1:0] c);
        logic [GROUP_W-1:0] b;
        case (c)
            3'b000:  b = 3'b000;
            3'b001:  b = 3'b001;
            3'b011:  b = 3'b010;
            3'b010:  b = 3'b011;
            3'b110:  b = 3'b100;
            3'b111:  b = 3'b101;
            3'b101:  b = 3'b110;
            default: b = 3'b111;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/verici_group_enc.sv
`default_nettype none
// ============================================================================
//  Module   : verici_group_enc
//  Brief    : Combinational 3-bit group to Gray codeword lookup.
//  Revision : 1.0 - initial release
// ============================================================================
module verici_group_enc
    import verici_pkg::*;
(
    input  logic [GROUP_W-1:0] i_group,
    output logic [GROUP_W-1:0] o_code
);

    always_comb begin
        o_code = enc_lut(i_group);
    end

endmodule
`default_nettype wire

// File: rtl/verici_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : verici_encoder
//  Brief    : Transmit-side encoder; Gray-codes an N-bit word one 3-bit group
//             per cycle with parallel/serial input and output modes.
//  Revision : 1.0 - initial release
// ============================================================================
module verici_encoder
    import verici_pkg::*;
#(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         basla,
    input  logic         mod1,
    input  logic         mod2,
    input  logic [N-1:0] gelen_veri,
    output logic [N-1:0] cikan_veri,
    output logic         bitti,
    output logic         mesgul
);

    localparam int G     = N / GROUP_W;
    localparam int CNT_W = $clog2(G + 1);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(G - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       shreg_q, shreg_d;
    logic [N-1:0]       cikan_q, cikan_d;
    logic               bitti_q, bitti_d;
    logic               mesgul_q, mesgul_d;
    logic               mod1_q, mod1_d;
    logic               mod2_q, mod2_d;

    logic [CNT_W-1:0]   w_pos;
    logic [GROUP_W-1:0] w_grp;
    logic [GROUP_W-1:0] w_code;

    // cnt walks groups MSB first, so the active group index is G-1-cnt
    assign w_pos = c_last_idx - cnt_q;
    assign w_grp = shreg_q[GROUP_W*w_pos +: GROUP_W];

    verici_group_enc u_group_enc (
        .i_group (w_grp),
        .o_code  (w_code)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        cikan_d  = cikan_q;
        bitti_d  = bitti_q;
        mesgul_d = mesgul_q;
        mod1_d   = mod1_q;
        mod2_d   = mod2_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (basla) begin
                    bitti_d  = 1'b0;
                    mesgul_d = 1'b1;
                    mod1_d   = mod1;
                    mod2_d   = mod2;
                    cnt_d    = '0;
                    if (!mod1) begin
                        shreg_d = gelen_veri;
                        state_d = ENCODE;
                    end else begin
                        shreg_d[GROUP_W*(G-1) +: GROUP_W] = gelen_veri[GROUP_W-1:0];
                        if (G == 1) begin
                            state_d = ENCODE;
                        end else begin
                            state_d = LOAD;
                            cnt_d   = c_one;
                        end
                    end
                end
            end

            LOAD: begin
                if (basla && mod1_q) begin
                    shreg_d[GROUP_W*w_pos +: GROUP_W] = gelen_veri[GROUP_W-1:0];
                    cnt_d = cnt_q + c_one;
                    if (cnt_q == c_last_idx) begin
                        state_d = ENCODE;
                        cnt_d   = '0;
                    end
                end else begin
                    // dropped start mid-load abandons the partial word
                    state_d  = IDLE;
                    mesgul_d = 1'b0;
                    bitti_d  = 1'b0;
                end
            end

            ENCODE: begin
                if (mod2_q) begin
                    cikan_d                = '0;
                    cikan_d[GROUP_W-1:0]   = w_code;
                end else begin
                    cikan_d[GROUP_W*w_pos +: GROUP_W] = w_code;
                end
                cnt_d = cnt_q + c_one;
                if (cnt_q == c_last_idx) begin
                    state_d  = DONE;
                    bitti_d  = 1'b1;
                    mesgul_d = 1'b0;
                    cnt_d    = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            cikan_q  <= '0;
            bitti_q  <= 1'b0;
            mesgul_q <= 1'b0;
            mod1_q   <= 1'b0;
            mod2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            cikan_q  <= cikan_d;
            bitti_q  <= bitti_d;
            mesgul_q <= mesgul_d;
            mod1_q   <= mod1_d;
            mod2_q   <= mod2_d;
        end
    end

    assign cikan_veri = cikan_q;
    assign bitti      = bitti_q;
    assign mesgul     = mesgul_q;

endmodule
`default_nettype wire

// File: doc/verici_encoder.md
Name: verici_encoder

Overview:
- Transmit-side encoder: maps each 3-bit group of an N-bit word to a 3-bit codeword, one group per cycle.
- The matching receive side is verici_decoder, which applies the inverse mapping.
- mod1 selects parallel or serial (3-bit per cycle) input; mod2 selects parallel or serial output.
- Sits between the data source and the channel. Handshake is basla/bitti.

Parameters:
- N, 12, word width in bits. Must be a multiple of 3 and at least 3. G = N/3 groups.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- basla  input  1  start. In serial-input mode it is held high while groups are supplied.
- mod1  input  1  0 = parallel input (whole word), 1 = serial input (gelen_veri[2:0], MSB group first).
- mod2  input  1  0 = parallel output, 1 = serial output on cikan_veri[2:0], MSB group first.
- gelen_veri  input  N  input data.
- cikan_veri  output  N  encoded word (parallel) or current codeword in [2:0] with upper bits 0 (serial).
- bitti  output  1  transaction complete.
- mesgul  output  1  high from the accepted start until bitti rises.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cikan_veri=0, bitti=0, mesgul=0, counters 0, shift register 0.
- Codeword mapping: Gray code per group, ENC_LUT: 000→000, 001→001, 010→011, 011→010, 100→110, 101→111, 110→101, 111→100.
- States: IDLE, LOAD, ENCODE, DONE.
- Mode latching: mod1 and mod2 are sampled at the start edge E0 and held in registers for the whole transaction.
- IDLE or DONE, basla=1 at edge E0:
  - bitti cleared to 0, mesgul set to 1.
  - mod1=0: gelen_veri loaded into the shift register; go to ENCODE.
  - mod1=1: gelen_veri[2:0] stored as group G-1; go to LOAD with cnt=1.
- LOAD: each edge with basla=1 stores gelen_veri[2:0] as the next lower group and increments cnt. When cnt reaches G, go to ENCODE.
  - basla=0 in LOAD aborts: return to IDLE, mesgul=0, bitti=0, cikan_veri unchanged.
  - For G=1, LOAD is skipped and the design goes straight to ENCODE.
- ENCODE: one group per edge, MSB group first, G edges total.
  - mod2=0: the encoded group is written into its position in cikan_veri; other bits keep their values until the word is complete.
  - mod2=1: cikan_veri = {0, code} each edge, so a new codeword appears every cycle.
  - On the G-th ENCODE edge: go to DONE, bitti=1, mesgul=0 on the same edge. In serial output, bitti coincides with the last codeword.
- Parallel-in latency: bitti is visible G cycles after E0. Serial-in latency: 2G-1 cycles after E0 (E0 counted as edge 0).
- DONE: cikan_veri and bitti are held until the next basla=1, which starts a new transaction on that edge. There is no idle gap.
- basla while in LOAD is data. basla while in ENCODE is ignored.
- Reset mid-transaction: immediate return to the reset values. The partial word is discarded.
- Widths: cnt is $clog2(G+1) bits. No arithmetic beyond the counter increment. Group index i covers bits [3i+2:3i].

Decomposition:
- Package verici_pkg holds:
  - the ENC_LUT function/constant and the DEC_LUT inverse, shared with verici_decoder;
  - the state enum (IDLE, LOAD, ENCODE, DONE);
  - GROUP_W=3.
- One sub-module, verici_group_enc: a combinational 3-bit lookup using ENC_LUT, instantiated once.
- The FSM, shift register and counter stay in verici_encoder.

Test Plan:
- Parallel/parallel, N=12:
  - Stimulus: gelen_veri=011100010110, 1-cycle basla.
  - Required: bitti=1 exactly 4 cycles after E0, cikan_veri=010110011101, mesgul low from that same edge.
- Serial-in/parallel-out:
  - Stimulus: basla high 4 cycles with 011, 100, 010, 110.
  - Required: cikan_veri=010110011101, bitti high 7 cycles after E0.
- Parallel-in/serial-out:
  - Stimulus: same word as the first scenario.
  - Required: cikan_veri[2:0] sequence 010, 110, 011, 101 on consecutive cycles, bitti rising with 101, cikan_veri[11:3]=0.
- Serial/serial, back-to-back:
  - Stimulus: serial input 101, 011, 001, 101, with the next basla issued on the DONE cycle.
  - Required: output sequence 111, 010, 001, 111; the second transaction starts without an idle cycle; bitti drops on the restart edge.
- Abort and reset:
  - Stimulus: basla dropped after 2 serial groups.
  - Required: return to IDLE, bitti=0, prior cikan_veri kept.
  - Stimulus: rst=0 in the middle of ENCODE.
  - Required: cikan_veri=0, bitti=0, mesgul=0 asynchronously. A following parallel transaction of 101011001101 gives 111010001111.
